// File: rtl/xy_dac_tx.sv
// xy_dac_tx: serial X/Y DAC transmitter; define DAC_SKIP_DUP_EN to skip frames for unchanged channels
module xy_dac_tx #(
  parameter int CLK_DIV   = 2,
  parameter int FRAME_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       dac_cs_n,
  output logic       dac_ldac_n
);
  typedef enum logic [2:0] {IDLE, SHIFT_X, GAP, SHIFT_Y, LOAD} state_t;
  localparam logic [15:0] DIV_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_END  = 16'(FRAME_GAP * CLK_DIV - 1);
  localparam logic [15:0] LOAD_END = 16'(2 * CLK_DIV - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        skip_y_q, skip_y_d;
  logic        in_ready_q, in_ready_d, sclk_q, sclk_d, din_q, din_d;
  logic        cs_n_q, cs_n_d, ldac_n_q, ldac_n_d;
  logic        accept, skip_x, skip_y, shifting, bit_end;
  logic [11:0] word;
  assign accept   = (state_q == IDLE) & in_valid & in_ready_q;
  assign shifting = (state_q == SHIFT_X) | (state_q == SHIFT_Y);
  assign bit_end  = (cnt_q == DIV_END) & phase_q & (bit_q == 4'd0);
`ifdef DAC_SKIP_DUP_EN
  logic [7:0] last_x_q, last_x_d, last_y_q, last_y_d;
  logic       sent_q, sent_d;
  assign skip_x = sent_q & (x == last_x_q);
  assign skip_y = sent_q & (y == last_y_q);
  // Track the values the DAC currently holds so repeated coordinates can be elided
  always_comb begin
    last_x_d = accept ? x : last_x_q;
    last_y_d = accept ? y : last_y_q;
    sent_d   = sent_q | accept;
  end
  // Last-sent registers; cleared so the first point after reset is always sent
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_x_q <= '0;
      last_y_q <= '0;
      sent_q   <= 1'b0;
    end else begin
      last_x_q <= last_x_d;
      last_y_q <= last_y_d;
      sent_q   <= sent_d;
    end
  end
`else
  assign skip_x = 1'b0;
  assign skip_y = 1'b0;
`endif
  // State register with divider, bit counter and latched point
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      skip_y_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      x_q      <= x_d;
      y_q      <= y_d;
      skip_y_q <= skip_y_d;
    end
  end
  // Next-state: frames in order X, gap, Y, load; skipped frames bypass the gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (skip_x & skip_y) ? IDLE : skip_x ? SHIFT_Y : SHIFT_X;
      SHIFT_X: if (bit_end) state_d = skip_y_q ? LOAD : GAP;
      GAP:     if (cnt_q == GAP_END) state_d = SHIFT_Y;
      SHIFT_Y: if (bit_end) state_d = LOAD;
      LOAD:    if (cnt_q == LOAD_END) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Divider restarts on every state change; bit counter reloads to 11 outside a frame
  always_comb begin
    cnt_d    = (state_q == IDLE || state_d != state_q || (shifting && cnt_q == DIV_END)) ? 16'd0 : cnt_q + 16'd1;
    phase_d  = (!shifting || state_d != state_q) ? 1'b0 : (cnt_q == DIV_END) ? ~phase_q : phase_q;
    bit_d    = (!shifting || state_d != state_q) ? 4'd11 : (cnt_q == DIV_END && phase_q) ? bit_q - 4'd1 : bit_q;
    x_d      = accept ? x : x_q;
    y_d      = accept ? y : y_q;
    skip_y_d = accept ? skip_y : skip_y_q;
  end
  // Pin values for the next cycle; the extra cycle keeps in_ready aligned with ldac_n rising
  always_comb begin
    word       = (state_q == SHIFT_Y) ? {4'b0100, y_q} : {4'b0000, x_q};
    in_ready_d = (state_q == IDLE) & ~accept;
    sclk_d     = shifting & phase_q;
    din_d      = shifting & word[bit_q];
    cs_n_d     = ~shifting;
    ldac_n_d   = state_q != LOAD;
  end
  // Registered pins so the link is glitch-free
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready_q <= 1'b1;
      sclk_q     <= 1'b0;
      din_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      ldac_n_q   <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      cs_n_q     <= cs_n_d;
      ldac_n_q   <= ldac_n_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_ldac_n = ldac_n_q;
endmodule
